// File: rtl/motor_uart_pkg.sv
// Shared types and helpers for the motor command packetizer.
package motor_uart_pkg;

    // Packet framing phases; CSUM is only reachable when checksums are built in
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        CSUM = 2'd3
    } pkt_state_t;

    localparam logic [7:0] PKT_HEADER = 8'hAA;

    // Two's-complement negation, so adding the result to acc wraps to zero
    function automatic logic [31:0] pkt_csum(input logic [31:0] acc);
        return (~acc) + 32'd1;
    endfunction

endpackage

// File: rtl/motor_cmd_packetizer.sv
// Frames one command word into HEADER + payload (+ checksum) bytes for the UART TX.
// Optional feature macro: MOTOR_PKT_CHECKSUM_EN appends a zero-sum checksum byte.
module motor_cmd_packetizer
    import motor_uart_pkg::*;
#(
    parameter int                BITS_N        = 8,
    parameter int                PAYLOAD_BYTES = 4,
    parameter logic [BITS_N-1:0] HEADER        = BITS_N'(PKT_HEADER)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PAYLOAD_BYTES*BITS_N-1:0] cmd_data,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    output logic [BITS_N-1:0]           byte_data,
    output logic                        byte_valid,
    input  logic                        byte_ready,
    output logic                        busy
);

    localparam int CMD_W = PAYLOAD_BYTES * BITS_N;
    localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);

    pkt_state_t         r_state;
    pkt_state_t         w_nextState;
    logic [CMD_W-1:0]   r_cmd;
    logic [IDX_W-1:0]   r_idx;
    logic [BITS_N-1:0]  w_payByte;
    logic               w_lastIdx;
    logic               w_accept;
    logic               w_handshake;

`ifdef MOTOR_PKT_CHECKSUM_EN
    logic [BITS_N-1:0]  r_acc;
    logic [BITS_N-1:0]  w_csum;

    assign w_csum = BITS_N'(pkt_csum(32'(r_acc)));
`endif

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_handshake = byte_valid && byte_ready;
    assign w_lastIdx   = (r_idx == IDX_W'(PAYLOAD_BYTES - 1));

    // Pick payload byte idx of the latched command, most significant byte first
    always_comb begin
        w_payByte = '0;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_payByte = r_cmd[CMD_W-1-i*BITS_N -: BITS_N];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: each byte phase advances only on a completed handshake
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (cmd_valid) w_nextState = HDR;
            HDR:  if (byte_ready) w_nextState = PAY;
            PAY: begin
                if (byte_ready && w_lastIdx) begin
`ifdef MOTOR_PKT_CHECKSUM_EN
                    w_nextState = CSUM;
`else
                    w_nextState = IDLE;
`endif
                end
            end
`ifdef MOTOR_PKT_CHECKSUM_EN
            CSUM: if (byte_ready) w_nextState = IDLE;
`endif
            default: w_nextState = IDLE;
        endcase
    end

    // Moore outputs decoded from registered state only, so byte_ready never reaches byte_valid
    always_comb begin
        cmd_ready  = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        case (r_state)
            IDLE: cmd_ready = 1'b1;
            HDR: begin
                byte_valid = 1'b1;
                byte_data  = HEADER;
            end
            PAY: begin
                byte_valid = 1'b1;
                byte_data  = w_payByte;
            end
`ifdef MOTOR_PKT_CHECKSUM_EN
            CSUM: begin
                byte_valid = 1'b1;
                byte_data  = w_csum;
            end
`endif
            default: cmd_ready = 1'b0;
        endcase
        busy = !cmd_ready;
    end

    // Command latch and payload index; the command only changes on acceptance in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
            r_idx <= '0;
        end else begin
            if (w_accept) begin
                r_cmd <= cmd_data;
                r_idx <= '0;
            end else if (r_state == PAY && w_handshake) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

`ifdef MOTOR_PKT_CHECKSUM_EN
    // Running modulo-2^BITS_N sum of every byte already sent in this packet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= '0;
            end else if (r_state == HDR && w_handshake) begin
                r_acc <= r_acc + HEADER;
            end else if (r_state == PAY && w_handshake) begin
                r_acc <= r_acc + w_payByte;
            end
        end
    end
`endif

endmodule

// File: tb/tb_motor_cmd_packetizer.sv
// Directed plus randomized bench for motor_cmd_packetizer, checked against a packet-level model.
module tb_motor_cmd_packetizer;

    logic        clk;
    logic        rst;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] got[$];
    logic [7:0] exp[$];

    motor_cmd_packetizer #(
        .BITS_N(8),
        .PAYLOAD_BYTES(4),
        .HEADER(8'hAA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_data(cmd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .byte_data(byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .busy(busy)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte that will be transferred on the coming rising edge
    always @(negedge clk) begin
        if (!rst && byte_valid && byte_ready) got.push_back(byte_data);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference packet: header, payload MSB first, then the byte making the total sum 0 mod 256
    task automatic buildPacket(input logic [31:0] cmd);
        int sum;
        int b;
        sum = 'hAA;
        exp.push_back(8'hAA);
        for (int i = 0; i < 4; i++) begin
            b = int'((cmd >> (8 * (3 - i))) & 32'hFF);
            sum += b;
            exp.push_back(8'(b));
        end
`ifdef MOTOR_PKT_CHECKSUM_EN
        exp.push_back(8'((256 - (sum % 256)) % 256));
`endif
    endtask

    // Offer one command from IDLE and confirm the header shows up the cycle after acceptance
    task automatic applyStimulus(input logic [31:0] cmd, input string tag);
        @(posedge clk); #1;
        checkOutput({tag, "_ready_before"}, cmd_ready, 1'b1);
        cmd_data  = cmd;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput({tag, "_hdr_valid"}, byte_valid, 1'b1);
        checkOutput({tag, "_hdr_data"}, byte_data, 8'hAA);
        checkOutput({tag, "_busy"}, busy, 1'b1);
    endtask

    task automatic waitBytes(input int n, input int budget, input string tag);
        for (int c = 0; c < budget && got.size() < n; c++) begin
            @(negedge clk); #1;
        end
        checkOutput({tag, "_no_timeout"}, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic compareQueues(input string tag);
        checkOutput({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
        end
    endtask

    initial begin
        int pktLen;
        int seenIdle;
        logic [31:0] rcmd;

        rst        = 1'b1;
        cmd_data   = '0;
        cmd_valid  = 1'b0;
        byte_ready = 1'b0;
        exp.delete();
        buildPacket(32'h0);
        pktLen = exp.size();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_byte_valid", byte_valid, 1'b0);
        checkOutput("rst_byte_data", byte_data, 8'h00);
        rst = 1'b0;

        // Single packet with the UART always ready
        byte_ready = 1'b1;
        got.delete(); exp.delete();
        buildPacket(32'h01020304);
        applyStimulus(32'h01020304, "single");
        waitBytes(exp.size(), 50, "single");
        @(posedge clk); #1;
        checkOutput("single_ready_back", cmd_ready, 1'b1);
        checkOutput("single_no_extra_valid", byte_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        compareQueues("single");

        // Back-pressure for 10 cycles while byte 02 is presented
        got.delete(); exp.delete();
        buildPacket(32'h01020304);
        applyStimulus(32'h01020304, "bp");
        for (int c = 0; c < 50 && !(byte_valid && byte_data == 8'h01); c++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        byte_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            checkOutput($sformatf("bp_hold_data%0d", c), byte_data, 8'h02);
            checkOutput($sformatf("bp_hold_valid%0d", c), byte_valid, 1'b1);
        end
        @(posedge clk); #1;
        byte_ready = 1'b1;
        waitBytes(exp.size(), 50, "bp");
        repeat (3) @(posedge clk);
        #1;
        compareQueues("bp");

        // Back-to-back commands with cmd_valid held high
        got.delete(); exp.delete();
        buildPacket(32'h01020304);
        buildPacket(32'hFFFFFFFF);
        @(posedge clk); #1;
        cmd_data  = 32'h01020304;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_data = 32'hFFFFFFFF;
        checkOutput("b2b_first_hdr", byte_data, 8'hAA);
        seenIdle = 0;
        for (int c = 0; c < 60 && !cmd_ready; c++) begin
            @(negedge clk); #1;
        end
        checkOutput("b2b_first_done", 32'(got.size()), 32'(pktLen));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("b2b_second_accepted", cmd_ready, 1'b0);
        checkOutput("b2b_second_hdr_valid", byte_valid, 1'b1);
        checkOutput("b2b_second_hdr_data", byte_data, 8'hAA);
        waitBytes(exp.size(), 60, "b2b");
        repeat (3) @(posedge clk);
        #1;
        compareQueues("b2b");

        // Command pulsed while busy must be ignored
        got.delete(); exp.delete();
        buildPacket(32'h01020304);
        applyStimulus(32'h01020304, "busy");
        for (int c = 0; c < 50 && !(byte_valid && byte_data == 8'h02); c++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_data  = 32'hDEADBEEF;
        cmd_valid = 1'b1;
        checkOutput("busy_not_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        waitBytes(exp.size(), 50, "busy");
        repeat (5) @(posedge clk);
        #1;
        checkOutput("busy_idle_after", byte_valid, 1'b0);
        compareQueues("busy");

        // Reset after header plus two payload bytes, then a fresh packet
        got.delete(); exp.delete();
        applyStimulus(32'h01020304, "rstmid");
        for (int c = 0; c < 50 && got.size() < 3; c++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rstmid_valid", byte_valid, 1'b0);
        checkOutput("rstmid_ready", cmd_ready, 1'b1);
        checkOutput("rstmid_data", byte_data, 8'h00);
        checkOutput("rstmid_partial_len", 32'(got.size()), 32'd3);
        got.delete(); exp.delete();
        buildPacket(32'h11223344);
        applyStimulus(32'h11223344, "rstnew");
        waitBytes(exp.size(), 50, "rstnew");
        repeat (3) @(posedge clk);
        #1;
        compareQueues("rstnew");

        // Random commands under random back-pressure
        for (int k = 0; k < 6; k++) begin
            rcmd = $urandom;
            got.delete(); exp.delete();
            buildPacket(rcmd);
            byte_ready = 1'($urandom_range(0, 1));
            applyStimulus(rcmd, $sformatf("rand%0d", k));
            for (int c = 0; c < 400 && got.size() < exp.size(); c++) begin
                @(posedge clk); #1;
                byte_ready = 1'($urandom_range(0, 1));
            end
            byte_ready = 1'b1;
            @(posedge clk); #1;
            checkOutput($sformatf("rand%0d_idle", k), cmd_ready, 1'b1);
            compareQueues($sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
